// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus controller: FSM state encoding,
// master/slave counts and the address-to-chip-select decode.
package bus_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Two top address bits select one of four slaves; result is active-low one-hot.
  function automatic logic [NUM_SLAVES-1:0] slave_cs_n(input logic [1:0] sel);
    logic [NUM_SLAVES-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/bus_if.sv
// Bundle of master-side and slave-side bus signals around the controller.
// The controller owns the 'master' modport; the bus environment uses 'slave'.
interface bus_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [NUM_MASTERS-1:0]        gnt_n;
  logic [NUM_MASTERS-1:0]        m_as_n;
  logic [NUM_MASTERS-1:0]        m_rw;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]        m_rdy_n;
  logic [NUM_MASTERS-1:0]        m_err_n;
  logic [NUM_SLAVES-1:0]         s_cs_n;
  logic                          s_as_n;
  logic                          s_rw;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_rdy_n;
  logic                          busy;

  modport master (
    input  gnt_n, m_as_n, m_rw, m_addr, m_wdata, s_rdata, s_rdy_n,
    output m_rdata, m_rdy_n, m_err_n, s_cs_n, s_as_n, s_rw, s_addr, s_wdata, busy
  );

  modport slave (
    output gnt_n, m_as_n, m_rw, m_addr, m_wdata, s_rdata, s_rdy_n,
    input  m_rdata, m_rdy_n, m_err_n, s_cs_n, s_as_n, s_rw, s_addr, s_wdata, busy
  );

endinterface

// File: rtl/bus_watchdog.sv
// WAIT-state cycle counter: counts up from zero while enabled and flags the
// cycle in which the count sits at TIMEOUT-1.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = en && (r_count == TERM_CNT);

endmodule

// File: rtl/bus_ctrl.sv
// Single-transaction bus controller: accepts one granted master, runs the
// slave access with a timeout, and returns a one-cycle ready/error pulse.
//
// state | meaning
// IDLE  | waiting for exactly one grant with its address strobe
// ADDR  | one-cycle address phase to the decoded slave
// WAIT  | holding strobe until slave ready or timeout
// RESP  | one-cycle ready (and error) pulse to the latched owner
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic  clk,
  input  logic  reset,
  bus_if.master bus
);

  state_t r_state, w_next;

  logic [1:0]        r_owner;
  logic              r_rw;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]             w_gnt_idx;
  logic [2:0]             w_gnt_cnt;
  logic                   w_accept;
  logic                   w_slv_rdy;
  logic                   w_expired;
  logic                   w_busy;
  logic                   w_s_as_n;
  logic [NUM_SLAVES-1:0]  w_s_cs_n;
  logic [NUM_MASTERS-1:0] w_m_rdy_n;
  logic [NUM_MASTERS-1:0] w_m_err_n;

  // A request is only legal with exactly one grant low and that master strobing.
  always_comb begin
    w_gnt_cnt = '0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!bus.gnt_n[i]) begin
        w_gnt_cnt = w_gnt_cnt + 3'd1;
        w_gnt_idx = 2'(i);
      end
    end
    w_accept = (w_gnt_cnt == 3'd1) && !bus.m_as_n[w_gnt_idx];
  end

  assign w_slv_rdy = !bus.s_rdy_n;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (r_state == ST_ADDR),
    .en      (r_state == ST_WAIT),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_busy    = (r_state != ST_IDLE);
    w_s_as_n  = 1'b1;
    w_s_cs_n  = '1;
    w_m_rdy_n = '1;
    w_m_err_n = '1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_s_as_n = 1'b0;
        w_s_cs_n = slave_cs_n(r_addr[ADDR_W-1 -: 2]);
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        w_s_as_n = 1'b0;
        w_s_cs_n = slave_cs_n(r_addr[ADDR_W-1 -: 2]);
        if (w_slv_rdy || w_expired) w_next = ST_RESP;
      end
      ST_RESP: begin
        w_m_rdy_n[r_owner] = 1'b0;
        if (r_err) w_m_err_n[r_owner] = 1'b0;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Slave ready wins over expiry on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= '0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_owner <= w_gnt_idx;
        r_rw    <= bus.m_rw[w_gnt_idx];
        r_addr  <= bus.m_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_wdata <= bus.m_wdata[w_gnt_idx*DATA_W +: DATA_W];
      end
      if (r_state == ST_WAIT) begin
        if (w_slv_rdy) begin
          r_err <= 1'b0;
          if (r_rw) r_rdata <= bus.s_rdata;
        end else if (w_expired) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.s_as_n  = w_s_as_n;
  assign bus.s_cs_n  = w_s_cs_n;
  assign bus.m_rdy_n = w_m_rdy_n;
  assign bus.m_err_n = w_m_err_n;
  assign bus.s_rw    = r_rw;
  assign bus.s_addr  = r_addr;
  assign bus.s_wdata = r_wdata;
  assign bus.m_rdata = r_rdata;

endmodule
